// File: rtl/alu_input_sequencer.sv
// Purpose : debounces three buttons and latches operand A, operand B and the opcode
//           from the switch bank in order, qualifying the values fed to the ALU.
// Ports   : clk/i_reset (async, active-high), i_sw switch bank, i_btn_a/b/op raw
//           buttons; o_datoA/o_datoB/o_operation to ALU, o_valid (RUN), o_state, o_err.
// Latency : steady raw press -> outputs update on the (DEBOUNCE_CYCLES+3)th edge;
//           all outputs are registered, so there is no input-to-output combinational path.
module alu_input_sequencer #(
    parameter int NB_DATA         = 4,
    parameter int NB_OP           = 6,
    parameter int NB_SW           = 8,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_valid,
    output logic [1:0]         o_state,
    output logic               o_err
);

    // Counter only needs to hold 0..DEBOUNCE_CYCLES-1; the terminal count is
    // detected one short so the level flips on the DEBOUNCE_CYCLES-th differing cycle.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        RUN     = 2'b11
    } state_t;

    // Button index: 0 = A, 1 = B, 2 = OP
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d;
    logic [2:0]       press_q, press_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_t              state_q, state_d;
    logic [NB_DATA-1:0]  datoA_q, datoA_d;
    logic [NB_DATA-1:0]  datoB_q, datoB_d;
    logic [NB_OP-1:0]    op_q, op_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [NB_DATA-1:0]  sw_data;
    logic [NB_OP-1:0]    sw_op;
    logic                op_ok;
    logic                ev_a, ev_b, ev_op;
    logic                unused_sw_hi;

    assign btn_raw      = {i_btn_op, i_btn_b, i_btn_a};
    assign sw_data      = i_sw[NB_DATA-1:0];
    assign sw_op        = i_sw[NB_OP-1:0];
    assign unused_sw_hi = ^i_sw;

    // Debounce: count while the synchronized level disagrees with the accepted
    // level, restart on any agreement. A press pulse is registered on the 0->1 flip.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]   = cnt_q[i];
            deb_d[i]   = deb_q[i];
            press_d[i] = 1'b0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i]   = ~deb_q[i];
                    cnt_d[i]   = '0;
                    press_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // One event serviced per cycle, A > B > OP; losers are dropped.
    assign ev_a  = press_q[0];
    assign ev_b  = press_q[1] & ~press_q[0];
    assign ev_op = press_q[2] & ~press_q[1] & ~press_q[0];

    always_comb begin
        op_ok = 1'b0;
        case (sw_op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000011), NB_OP'(6'b000010): op_ok = 1'b1;
            default:                              op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        datoA_d = datoA_q;
        datoB_d = datoB_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (ev_a) begin
                    datoA_d = sw_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (ev_a) begin
                    datoA_d = sw_data;
                end else if (ev_b) begin
                    datoB_d = sw_data;
                    state_d = WAIT_OP;
                end
            end
            default: begin  // WAIT_OP and RUN share the edit/accept rules
                if (ev_a) begin
                    datoA_d = sw_data;
                end else if (ev_b) begin
                    datoB_d = sw_data;
                end else if (ev_op) begin
                    if (op_ok) begin
                        op_d    = sw_op;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
        // Registered from next state so o_valid rises together with o_state == RUN.
        valid_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= WAIT_A;
            datoA_q <= '0;
            datoB_q <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            datoA_q <= datoA_d;
            datoB_q <= datoB_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_datoA     = datoA_q;
    assign o_datoB     = datoB_q;
    assign o_operation = op_q;
    assign o_valid     = valid_q;
    assign o_state     = state_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Purpose : directed self-checking bench for alu_input_sequencer (DEBOUNCE_CYCLES=4).
// Timing  : inputs driven 1ns after a rising edge, outputs sampled at the same point.
// Checks  : reset, load order, latency, opcode rejection, priority, glitch/bounce.
module tb_alu_input_sequencer;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_sw;
    logic       i_btn_a, i_btn_b, i_btn_op;
    logic [3:0] o_datoA, o_datoB;
    logic [5:0] o_operation;
    logic       o_valid, o_err;
    logic [1:0] o_state;

    int tests    = 0;
    int failures = 0;
    int err_cycles = 0;
    int err_base;

    always #5 clk = ~clk;

    always @(negedge clk) if (o_err === 1'b1) err_cycles++;

    alu_input_sequencer #(
        .NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_sw(i_sw),
        .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
        .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
        .o_valid(o_valid), .o_state(o_state), .o_err(o_err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // which: 0 = A, 1 = B, 2 = OP. Held 10 cycles then released 12 cycles.
    task automatic press(input int which);
        case (which)
            0: i_btn_a  = 1'b1;
            1: i_btn_b  = 1'b1;
            default: i_btn_op = 1'b1;
        endcase
        tick(10);
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        tick(12);
    endtask

    initial begin
        i_reset = 1'b1; i_sw = 8'h00;
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        tick(3);
        check("rst_datoA", 8'(o_datoA), 8'h0);
        check("rst_datoB", 8'(o_datoB), 8'h0);
        check("rst_op",    8'(o_operation), 8'h0);
        check("rst_valid", 8'(o_valid), 8'h0);
        check("rst_err",   8'(o_err), 8'h0);
        check("rst_state", 8'(o_state), 8'h0);
        i_reset = 1'b0;
        tick(2);

        // Reset in the middle of an A debounce must discard it
        i_sw = 8'h0F; i_btn_a = 1'b1;
        tick(4);
        i_reset = 1'b1;
        #1;
        check("midrst_state_in_rst", 8'(o_state), 8'h0);
        i_btn_a = 1'b0;
        tick(2);
        i_reset = 1'b0;
        tick(12);
        check("midrst_datoA", 8'(o_datoA), 8'h0);
        check("midrst_state", 8'(o_state), 8'h0);

        // B and OP are ignored in WAIT_A
        i_sw = 8'h05; press(1);
        i_sw = 8'h20; press(2);
        check("waitA_ignore_state", 8'(o_state), 8'h0);
        check("waitA_ignore_datoB", 8'(o_datoB), 8'h0);
        check("waitA_ignore_op",    8'(o_operation), 8'h0);

        // 3-cycle glitch on A is filtered
        i_sw = 8'h0A; i_btn_a = 1'b1;
        tick(3);
        i_btn_a = 1'b0;
        tick(12);
        check("glitch_state", 8'(o_state), 8'h0);
        check("glitch_datoA", 8'(o_datoA), 8'h0);

        // Latency: load lands on exactly the 7th edge after the first high sample
        i_sw = 8'h03; i_btn_a = 1'b1;
        tick(6);
        check("lat_datoA_e6", 8'(o_datoA), 8'h0);
        check("lat_state_e6", 8'(o_state), 8'h0);
        tick(1);
        check("lat_datoA_e7", 8'(o_datoA), 8'h3);
        check("lat_state_e7", 8'(o_state), 8'h1);
        tick(3);
        i_btn_a = 1'b0;
        tick(12);

        i_sw = 8'h05; press(1);
        check("B_datoB", 8'(o_datoB), 8'h5);
        check("B_state", 8'(o_state), 8'h2);
        check("B_valid", 8'(o_valid), 8'h0);

        // Invalid opcode in WAIT_OP: one-cycle error pulse
        i_sw = 8'h3F; i_btn_op = 1'b1;
        tick(6);
        check("inv_err_e6", 8'(o_err), 8'h0);
        tick(1);
        check("inv_err_e7", 8'(o_err), 8'h1);
        check("inv_state",  8'(o_state), 8'h2);
        check("inv_op",     8'(o_operation), 8'h0);
        tick(1);
        check("inv_err_e8", 8'(o_err), 8'h0);
        tick(2);
        i_btn_op = 1'b0;
        tick(12);
        check("inv_state_after", 8'(o_state), 8'h2);

        i_sw = 8'h03; press(2);
        check("sra_op",    8'(o_operation), 8'h03);
        check("sra_valid", 8'(o_valid), 8'h1);
        check("sra_state", 8'(o_state), 8'h3);

        i_sw = 8'h20; press(2);
        check("add_op",    8'(o_operation), 8'h20);
        check("add_state", 8'(o_state), 8'h3);

        // Invalid opcode in RUN: holds opcode, exactly one error cycle
        err_base = err_cycles;
        i_sw = 8'h3F; press(2);
        check("run_inv_op",    8'(o_operation), 8'h20);
        check("run_inv_state", 8'(o_state), 8'h3);
        check("run_inv_errcnt", 8'(err_cycles - err_base), 8'h1);

        i_sw = 8'h0C; press(0);
        check("live_datoA", 8'(o_datoA), 8'hC);
        check("live_valid", 8'(o_valid), 8'h1);
        check("live_state", 8'(o_state), 8'h3);

        // Upper switch bits are ignored
        i_sw = 8'hA6; press(1);
        check("hi_datoB", 8'(o_datoB), 8'h6);
        i_sw = 8'hE6; press(2);
        check("hi_op", 8'(o_operation), 8'h26);

        // Bounce on press and release: exactly one load, with the stable-phase value
        i_sw = 8'h01;
        i_btn_a = 1'b1; tick(3);
        i_btn_a = 1'b0; tick(1);
        i_btn_a = 1'b1; tick(2);
        i_btn_a = 1'b0; tick(1);
        check("bounce_pre_datoA", 8'(o_datoA), 8'hC);
        i_sw = 8'h07;
        i_btn_a = 1'b1; tick(10);
        check("bounce_datoA", 8'(o_datoA), 8'h7);
        i_sw = 8'h02;
        i_btn_a = 1'b0; tick(2);
        i_btn_a = 1'b1; tick(2);
        i_btn_a = 1'b0; tick(1);
        i_btn_a = 1'b1; tick(3);
        i_btn_a = 1'b0; tick(12);
        check("bounce_release_datoA", 8'(o_datoA), 8'h7);

        // Simultaneous A, B, OP from WAIT_A: only A serviced
        i_reset = 1'b1; tick(2);
        i_reset = 1'b0; tick(1);
        i_sw = 8'h09;
        i_btn_a = 1'b1; i_btn_b = 1'b1; i_btn_op = 1'b1;
        tick(10);
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        tick(12);
        check("simul_datoA", 8'(o_datoA), 8'h9);
        check("simul_state", 8'(o_state), 8'h1);
        check("simul_datoB", 8'(o_datoB), 8'h0);
        check("simul_op",    8'(o_operation), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
Front-end controller for the combinational ALU on the board. Debounces three push-buttons and uses them to latch operand A, operand B and the 6-bit opcode from the switch bank in a fixed order. Presents stable, qualified i_datoA / i_datoB / i_operation values to the ALU and flags when the ALU output (LEDs) is meaningful. Rejects unsupported opcodes.

Parameters:
- NB_DATA, 4, operand width (ALU i_datoA / i_datoB).
- NB_OP, 6, opcode width (ALU i_operation).
- NB_SW, 8, switch bank width; must be >= max(NB_DATA, NB_OP).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a button level change is accepted; must be >= 1.

Ports:
- clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_sw  in  NB_SW  raw switches; operands use i_sw[NB_DATA-1:0], opcode uses i_sw[NB_OP-1:0]
- i_btn_a  in  1  raw button, load operand A
- i_btn_b  in  1  raw button, load operand B
- i_btn_op  in  1  raw button, load opcode
- o_datoA  out  NB_DATA  latched operand A, to ALU
- o_datoB  out  NB_DATA  latched operand B, to ALU
- o_operation  out  NB_OP  latched opcode, to ALU
- o_valid  out  1  high when all three are loaded (state RUN)
- o_state  out  2  current FSM state encoding
- o_err  out  1  one-cycle pulse on opcode rejection

Behaviour:
- Reset (async, active-high, any time including mid-debounce):
  - o_datoA = 0, o_datoB = 0, o_operation = 0.
  - o_valid = 0, o_err = 0, o_state = WAIT_A.
  - All synchronizer, debounce and counter state cleared; debounced levels = 0.
- Button path, per button, independent:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized level differs from the debounced level; it clears whenever they are equal.
  - The debounced level toggles when the counter reaches DEBOUNCE_CYCLES.
  - A press event is a one-cycle pulse on the debounced 0->1 transition. Releases generate no event.
  - Latency: raw high held steadily -> registered outputs/state change on exactly the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples the raw high.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
  - A held button produces exactly one event.
- Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL. All others are invalid.
- FSM, with o_state encoding:
  - WAIT_A (00):
    - A event: o_datoA <= i_sw[NB_DATA-1:0], go to WAIT_B.
    - B and OP events ignored.
  - WAIT_B (01):
    - B event: o_datoB <= i_sw[NB_DATA-1:0], go to WAIT_OP.
    - A event: reload o_datoA, stay in WAIT_B.
    - OP event ignored.
  - WAIT_OP (10):
    - OP event, valid opcode: o_operation <= opcode, go to RUN.
    - OP event, invalid opcode: o_operation unchanged, o_err pulses 1 cycle, stay in WAIT_OP.
    - A or B event: reload that operand, stay in WAIT_OP.
  - RUN (11):
    - o_valid = 1 (registered, asserted in the same cycle o_state becomes RUN).
    - Any event reloads the corresponding register (live edit) and stays in RUN.
    - Invalid opcode in RUN: o_err pulses, o_operation holds, stay in RUN.
- Simultaneous events in the same cycle: priority A > B > OP. Exactly one event is serviced per cycle; lower-priority events in that cycle are dropped, not queued.
- i_sw is sampled directly (quasi-static, no sync) on the event cycle. Upper switch bits beyond NB_DATA / NB_OP are ignored.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold reset 3 cycles -> all outputs 0, o_state = 00, o_valid = 0. Assert i_reset mid-debounce of i_btn_a -> no load after release of reset.
- i_sw=0x03, press A (hold 10 cycles) -> o_datoA = 0011 exactly 7 edges after the first high sample, o_state = 01. Then i_sw=0x05, press B -> o_datoB = 0101, state 10. Then i_sw=0x20, press OP -> o_operation = 100000, o_valid = 1, state 11.
- In WAIT_OP, i_sw=0x3F, press OP -> o_err pulses exactly 1 cycle, o_operation unchanged, state stays 10. Then i_sw=0x03 (SRA) -> accepted, RUN.
- From WAIT_A, press B and OP -> no change. Raise A, B and OP in the same cycle -> only A is loaded, state 01.
- Pulse i_btn_a for 3 cycles -> no event. Button bounce (1-cycle lows) during a press -> exactly one load.
- In RUN, i_sw=0x0C, press A -> o_datoA = 1100, o_valid stays 1, state 11.
